// File: rtl/fifo_sync_pointer_multi.sv
// Multi-channel Gray write-pointer synchroniser into the read clock domain, with registered
// binary conversion, advance count and change pulse; FIFO_SYNC_GRAY_CHECK_EN builds the Gray coherency check.
module fifo_sync_pointer_multi #(
    parameter int DEPTH        = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int NUM_CHANNELS = 1,
    localparam int PW          = $clog2(DEPTH) + 1
) (
    input  logic                         read_clock,
    input  logic                         read_reset_n,
    input  logic [NUM_CHANNELS*PW-1:0]   write_pointer_gray,
    input  logic                         clear_error,
    output logic [NUM_CHANNELS*PW-1:0]   synced_pointer_gray,
    output logic [NUM_CHANNELS*PW-1:0]   synced_pointer_bin,
    output logic [NUM_CHANNELS*PW-1:0]   pointer_advance,
    output logic [NUM_CHANNELS-1:0]      pointer_changed,
    output logic [NUM_CHANNELS-1:0]      gray_error
);

    localparam int WARM = SYNC_STAGES + 1;
    localparam int WW   = $clog2(WARM + 1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (SYNC_STAGES < 2) || (NUM_CHANNELS < 1)) begin : g_param_err
        $error("fifo_sync_pointer_multi: DEPTH must be a power of two >= 2, SYNC_STAGES >= 2, NUM_CHANNELS >= 1");
    end

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [NUM_CHANNELS*PW-1:0] r_sync [SYNC_STAGES];
    logic [WW-1:0]              r_warm;
    logic                       w_warm_done;
    logic [PW-1:0]              w_gray [NUM_CHANNELS];
    logic [PW-1:0]              w_bin  [NUM_CHANNELS];
    logic [PW-1:0]              r_bin  [NUM_CHANNELS];
    logic [PW-1:0]              r_adv  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]    r_chg;

    assign w_warm_done = (r_warm == WW'(WARM));

    // Synchroniser shift chain: plain flops only, stage 0 samples the async input directly.
    always_ff @(posedge read_clock) begin
        if (!read_reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= write_pointer_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Warm-up counter: saturates once the chain and conversion stage hold post-reset data.
    always_ff @(posedge read_clock) begin
        if (!read_reset_n) begin
            r_warm <= '0;
        end else if (!w_warm_done) begin
            r_warm <= r_warm + WW'(1);
        end else begin
            r_warm <= r_warm;
        end
    end

    // Per-channel split of the synchroniser output and Gray-to-binary decode.
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_gray[c] = r_sync[SYNC_STAGES-1][c*PW +: PW];
            w_bin[c]  = gray2bin(w_gray[c]);
        end
    end

    // Conversion stage: r_bin doubles as prev_bin, so it tracks the live value even in warm-up.
    always_ff @(posedge read_clock) begin
        if (!read_reset_n) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_bin[c] <= '0;
                r_adv[c] <= '0;
            end
            r_chg <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_bin[c] <= w_bin[c];
                if (w_warm_done) begin
                    r_adv[c] <= w_bin[c] - r_bin[c];
                    r_chg[c] <= (w_bin[c] != r_bin[c]);
                end else begin
                    r_adv[c] <= '0;
                    r_chg[c] <= 1'b0;
                end
            end
        end
    end

`ifdef FIFO_SYNC_GRAY_CHECK_EN
    function automatic logic [PW:0] popcount(input logic [PW-1:0] v);
        logic [PW:0] n;
        n = '0;
        for (int i = 0; i < PW; i++) begin
            n = n + {{PW{1'b0}}, v[i]};
        end
        return n;
    endfunction

    logic [PW-1:0]           r_gprev [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] r_err;

    // Sticky coherency flag; a new violation beats a simultaneous clear.
    always_ff @(posedge read_clock) begin
        if (!read_reset_n) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_gprev[c] <= '0;
            end
            r_err <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_gprev[c] <= w_gray[c];
                if (w_warm_done && (popcount(w_gray[c] ^ r_gprev[c]) > {{PW{1'b0}}, 1'b1})) begin
                    r_err[c] <= 1'b1;
                end else if (clear_error) begin
                    r_err[c] <= 1'b0;
                end else begin
                    r_err[c] <= r_err[c];
                end
            end
        end
    end

    assign gray_error = r_err;
`else
    logic w_unused_clear;
    assign w_unused_clear = clear_error;
    assign gray_error     = '0;
`endif

    assign synced_pointer_gray = r_sync[SYNC_STAGES-1];
    assign pointer_changed     = r_chg;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_pack
        assign synced_pointer_bin[c*PW +: PW] = r_bin[c];
        assign pointer_advance[c*PW +: PW]    = r_adv[c];
    end

endmodule

// File: tb/tb_fifo_sync_pointer_multi.sv
// Directed bench: single-channel DUT (DEPTH=16, SYNC_STAGES=2) plus a 3-channel, 3-stage DUT.
module tb_fifo_sync_pointer_multi;

`ifdef FIFO_SYNC_GRAY_CHECK_EN
    localparam logic E = 1'b1;
`else
    localparam logic E = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [4:0]  wp;
    logic [14:0] wp3;
    logic [4:0]  sg, sb, adv;
    logic [0:0]  chg, err;
    logic [14:0] sg3, sb3, adv3;
    logic [2:0]  chg3, err3;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    fifo_sync_pointer_multi #(.DEPTH(16), .SYNC_STAGES(2), .NUM_CHANNELS(1)) dut (
        .read_clock(clk), .read_reset_n(rst_n), .write_pointer_gray(wp), .clear_error(clr),
        .synced_pointer_gray(sg), .synced_pointer_bin(sb), .pointer_advance(adv),
        .pointer_changed(chg), .gray_error(err)
    );

    fifo_sync_pointer_multi #(.DEPTH(16), .SYNC_STAGES(3), .NUM_CHANNELS(3)) dut3 (
        .read_clock(clk), .read_reset_n(rst_n), .write_pointer_gray(wp3), .clear_error(clr),
        .synced_pointer_gray(sg3), .synced_pointer_bin(sb3), .pointer_advance(adv3),
        .pointer_changed(chg3), .gray_error(err3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sg"}, sg, 0);
        check({tag, "_sb"}, sb, 0);
        check({tag, "_adv"}, adv, 0);
        check({tag, "_chg"}, chg, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // One-edge reset with g held, then warm-up: no pulse, no error, bin settles after 3 edges.
    task automatic warm(input logic [4:0] g, input logic [4:0] b);
        wp    = g;
        rst_n = 1'b0;
        tick;
        check_zero("rst");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("warm_sg", sg, (i >= 1) ? g : 5'd0);
            check("warm_sb", sb, (i >= 2) ? b : 5'd0);
            check("warm_adv", adv, 0);
            check("warm_chg", chg, 0);
            check("warm_err", err, 0);
        end
    endtask

    // Drive g; sg after 2 edges, bin/advance/pulse after 3, pulse gone after 4.
    task automatic step(input logic [4:0] g, input logic [4:0] b_old, input logic [4:0] b_new,
                        input logic [4:0] adv_exp, input logic err_exp, input logic clr3);
        wp = g;
        tick;
        tick;
        check("step_sg", sg, g);
        check("step_sb_old", sb, b_old);
        if (clr3) clr = 1'b1;
        else      clr = 1'b0;
        tick;
        clr = 1'b0;
        check("step_sb", sb, b_new);
        check("step_adv", adv, adv_exp);
        check("step_chg", chg, 1);
        check("step_err", err, err_exp);
        tick;
        check("step_chg_off", chg, 0);
        check("step_adv_off", adv, 0);
        check("step_err_hold", err, err_exp);
    endtask

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        wp    = 5'd0;
        wp3   = 15'd0;
        repeat (3) tick;
        check_zero("reset");
        check("reset_sg3", sg3, 0);
        check("reset_chg3", chg3, 0);
        rst_n = 1'b1;
        repeat (4) tick;
        check("idle_sb", sb, 0);
        check("idle_chg", chg, 0);

        // latency from 0 to 1
        step(5'b00001, 5'd0, 5'd1, 5'd1, 1'b0, 1'b0);

        // warm-up with binary 16 held, then mid-operation resets at binary 9
        warm(5'b11000, 5'd16);
        warm(5'b01101, 5'd9);
        warm(5'b01101, 5'd9);

        // wrap 30 -> 31 -> 0
        warm(5'b10001, 5'd30);
        step(5'b10000, 5'd30, 5'd31, 5'd1, 1'b0, 1'b0);
        step(5'b00000, 5'd31, 5'd0, 5'd1, 1'b0, 1'b0);

        // coherency: 00000 -> 00011 (2 bits), clear, then set coinciding with clear
        step(5'b00011, 5'd0, 5'd2, 5'd2, E, 1'b0);
        clr = 1'b1;
        tick;
        clr = 1'b0;
        check("err_cleared", err, 0);
        step(5'b01100, 5'd2, 5'd8, 5'd6, E, 1'b1);

        // multi-channel: only channel 1 increments, 4-edge latency
        wp3 = 15'b00000_00001_00000;
        tick;
        check("mc_chg_e1", chg3, 0);
        tick;
        check("mc_chg_e2", chg3, 0);
        tick;
        check("mc_sg_e3", sg3, 15'h0020);
        check("mc_sb_e3", sb3, 0);
        check("mc_chg_e3", chg3, 0);
        tick;
        check("mc_chg_e4", chg3, 3'b010);
        check("mc_sb_e4", sb3, 15'h0020);
        check("mc_adv_e4", adv3, 15'h0020);
        check("mc_err_e4", err3, 0);
        tick;
        check("mc_chg_e5", chg3, 0);
        check("mc_adv_e5", adv3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_sync_pointer_multi.md
Name: fifo_sync_pointer_multi

Overview:
Parametrised multi-channel synchroniser that brings Gray-coded write pointers from asynchronous write domains into the read clock domain. Synchroniser depth is configurable. The block adds registered Gray-to-binary conversion, a per-channel advance count, a change pulse, and a sticky Gray-coherency error. It sits on the read side of one or more async FIFOs that share one read clock, and feeds the empty/level logic.

Parameters:
DEPTH, 16, FIFO entries per channel; power of two, at least 2. Pointer width PW = $clog2(DEPTH)+1.
SYNC_STAGES, 2, number of synchroniser flops per bit; at least 2.
NUM_CHANNELS, 1, number of independent pointers synchronised; at least 1.

Ports:
read_clock  input  1  read-domain clock; all flops on its rising edge.
read_reset_n  input  1  synchronous, active-low reset; sampled on the rising edge of read_clock.
write_pointer_gray  input  NUM_CHANNELS*PW  asynchronous Gray write pointers; channel c at [c*PW +: PW].
clear_error  input  1  synchronous clear of all gray_error bits.
synced_pointer_gray  output  NUM_CHANNELS*PW  synchroniser output, Gray code.
synced_pointer_bin  output  NUM_CHANNELS*PW  registered binary equivalent of synced_pointer_gray.
pointer_advance  output  NUM_CHANNELS*PW  binary entries advanced since the previous cycle, modulo 2^PW.
pointer_changed  output  NUM_CHANNELS  one-cycle pulse when a channel's binary pointer changes.
gray_error  output  NUM_CHANNELS  sticky flag: successive synced Gray values differ in more than one bit.

Behaviour:
- Reset: while read_reset_n=0 at a clock edge, every flop clears to 0, including all synchroniser stages, outputs and the warm-up counter. All outputs read 0 the cycle after reset.
- Synchroniser: SYNC_STAGES-deep shift chain per bit. No logic between stages; stage 1 samples write_pointer_gray directly.
  - A value sampled at edge k appears on synced_pointer_gray after edge k+SYNC_STAGES-1.
- Conversion stage, registered one cycle after synced_pointer_gray, so total latency is SYNC_STAGES+1 edges:
  - bin[PW-1] = g[PW-1]; bin[i] = bin[i+1] ^ g[i].
  - synced_pointer_bin holds the binary pointer.
  - A per-channel prev_bin register holds the last binary value. pointer_advance = bin_new - prev_bin, truncated to PW bits, so wrap-around is natural: 2*DEPTH-1 to 0 gives 1.
  - pointer_changed = (bin_new != prev_bin).
- Coherency check: per channel, popcount(g_new ^ g_prev) > 1 sets gray_error.
  - gray_error stays set until clear_error=1 or reset.
  - If set and clear coincide on the same edge, set wins.
  - Distance 0 or 1 never sets the flag.
- Warm-up:
  - After reset release, a shared counter counts SYNC_STAGES+1 edges.
  - Until it saturates, pointer_advance=0, pointer_changed=0 and no error can be set.
  - prev_bin and g_prev still track the live value during warm-up, so a non-zero pointer present at reset release never produces a spurious advance or error.
- Reset mid-operation: all state clears on that edge and warm-up restarts; no pulse or error from pre-reset state.
- Channels are fully independent apart from the shared reset, warm-up counter and clear_error.
- Parameter violation (DEPTH not a power of two, or SYNC_STAGES<2) is an elaboration-time error.

Optional Feature:
FIFO_SYNC_GRAY_CHECK_EN:
- Defined: coherency check and gray_error behave as specified above.
- Undefined: no check logic is built, gray_error is constant 0, clear_error is ignored, and all other behaviour is unchanged.

Test Plan:
- Reset and latency: DEPTH=16, SYNC_STAGES=2, write_pointer_gray=0, release reset, then drive Gray 5'b00001 at edge k -> synced_pointer_gray=00001 after edge k+1; synced_pointer_bin=1, pointer_advance=1, pointer_changed=1 after edge k+2, then pointer_changed=0.
- Wrap: step the Gray pointer through binary 30, 31, 0 (Gray 10001, 10000, 00000) -> synced_pointer_bin goes 30, 31, 0 with pointer_advance=1 on each step and gray_error=0.
- Coherency error, macro defined: jump Gray 00000 to 00011 -> gray_error=1 and it stays set; pulse clear_error -> 0; set and clear on the same edge -> stays 1. With macro undefined -> gray_error stays 0.
- Warm-up suppression: hold write_pointer_gray=11000 (binary 16) through reset release -> pointer_changed=0 and gray_error=0 throughout; synced_pointer_bin settles to 16 after SYNC_STAGES+1 edges.
- Multi-channel, depth-3: NUM_CHANNELS=3, SYNC_STAGES=3, increment only channel 1 -> only bit 1 of pointer_changed pulses, after 4 edges; channels 0 and 2 hold 0.
- Reset mid-operation: pointer at binary 9, assert read_reset_n=0 for one edge -> all outputs 0 on the next cycle; no pointer_changed pulse during the subsequent warm-up.
